spm_bg_arbiter: RTL and testbench
=================================

SPM_BG_ARBITER -- requirements
Module: spm_bg_arbiter

Interface
REQ-001 SHALL have parameter N_LSU, default 4, the number of LSU requesters.
REQ-002 SHALL have parameter N_BG, default 4, the number of scratchpad bank groups.
REQ-003 SHALL have parameter LEN_W, default 4, the burst-length field width; a burst is len+1 beats.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N_LSU  per-LSU request for exclusive bank-group access.
REQ-007 req_bg  input  N_LSU*2  per-LSU target bank group; LSU i uses bits [2i+1:2i].
REQ-008 req_len  input  N_LSU*LEN_W  per-LSU burst length minus one.
REQ-009 grant  output  N_LSU  bit i high while LSU i owns a bank group.
REQ-010 bg_busy  output  N_BG  bit b high while bank group b is owned.
REQ-011 bg_owner  output  N_BG*2  owning LSU index per bank group; this field drives the crossbar select.
REQ-012 last_beat  output  N_BG  bit b high in the final granted cycle of bank group b's burst.

Function
REQ-013 Each bank group SHALL run an independent 2-state FSM: IDLE, BUSY.
REQ-014 In IDLE, bank group b SHALL arbitrate among eligible LSUs: req_valid=1, req_bg=b, and not currently owning any bank group.
REQ-015 Arbitration SHALL be round-robin.
  - Search starts at rr_ptr[b].
  - After a grant, rr_ptr[b] = winner+1 mod N_LSU.
REQ-016 A winner at cycle t SHALL cause BUSY, bg_busy[b]=1, bg_owner[b]=winner and grant[winner]=1 from cycle t+1; this is 1-cycle latency.
REQ-017 On grant, the beat counter SHALL load the winner's req_len.
  - BUSY decrements it each cycle.
  - last_beat[b]=1 when the counter is 0.
  - The next cycle returns to IDLE.
  - The burst therefore lasts exactly len+1 cycles.
REQ-018 The FSM SHALL leave BUSY only at counter 0.
  - The requester may drop req_valid after grant without effect.
  - req_bg and req_len changes during BUSY SHALL be ignored.
REQ-019 A bank group SHALL spend one IDLE (arbitration) cycle between consecutive bursts.
  - Max throughput per bank group = (len+1)/(len+2).
REQ-020 If no LSU is eligible, the bank group SHALL stay IDLE with rr_ptr unchanged.
REQ-021 Different bank groups SHALL grant different LSUs in the same cycle independently.
  - An LSU SHALL never be granted two bank groups at once.
REQ-022 An LSU requesting in the same cycle its burst ends (last_beat) SHALL NOT be eligible until the following cycle.
REQ-023 In IDLE, bg_owner[b] SHALL hold its last value; consumers qualify it with bg_busy.
REQ-024 len=0 SHALL give a single-beat burst with last_beat in the grant cycle.
REQ-025 len=all-ones SHALL give a 2^LEN_W-beat burst; the counter SHALL NOT wrap.

Reset
REQ-026 While rst=1, all FSMs SHALL be IDLE, all rr_ptr=0, counters=0 and all outputs 0.
REQ-027 rst asserted mid-burst SHALL abort the burst.
  - grant, bg_busy and last_beat go to 0 on the next edge.
  - The aborted burst SHALL NOT resume after reset.

Structure
REQ-028 N_LSU, N_BG, LEN_W and the field widths of req_bg and bg_owner SHALL be defined in the shared param_define.v macro file.
REQ-029 A sub-module rr_arbiter_n (combinational round-robin pick from request vector and pointer) SHALL be instantiated once per bank group.
REQ-030 The FSM, counter and rr_ptr SHALL reside in spm_bg_arbiter.

Verification
REQ-031 Single request:
  - Stimulus: LSU0 req_bg=2, len=3 at cycle 5.
  - Response: grant[0], bg_busy[2]=1, bg_owner[2]=0 in cycles 6-9; last_beat[2] in cycle 9; IDLE in cycle 10.
REQ-032 Contention:
  - Stimulus: LSU0-3 all target bg 1 with len=0, held continuously from reset.
  - Response: grants in order LSU0,1,2,3,0 at cycles 2,4,6,8,10, with a bubble between grants.
REQ-033 Parallel:
  - Stimulus: LSU0->bg0, LSU1->bg1, LSU2->bg2, LSU3->bg3, len=1.
  - Response: all four grants high in the same two cycles; bg_owner={3,2,1,0}.
REQ-034 Hold semantics:
  - Stimulus: LSU2 len=7 to bg3, drops req_valid and changes req_bg to 0 after the first grant cycle.
  - Response: grant[2] stays high 8 cycles; bg0 stays IDLE.
REQ-035 Reset mid-burst:
  - Stimulus: rst=1 at the 3rd beat of a len=5 burst.
  - Response: all outputs 0 next cycle; after rst release with no requests, outputs stay 0.
REQ-036 Max length:
  - Stimulus: len=15.
  - Response: exactly 16 grant cycles, one last_beat pulse, no counter wrap.

Source files
------------

// File: rtl/spm_bg_arbiter_pkg.sv
// Shared parameters, FSM encodings and helpers for the scratchpad bank-group arbiter.
package spm_bg_arbiter_pkg;

  localparam int unsigned DefNLsu = 4;
  localparam int unsigned DefNBg  = 4;
  localparam int unsigned DefLenW = 4;

  // Width of an LSU index and of a bank-group index (req_bg / bg_owner fields).
  localparam int unsigned IdxW = 2;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // Round-robin successor of idx in a ring of n requesters.
  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] idx, input int unsigned n);
    return (int'(idx) == int'(n) - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/spm_bg_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter_n
  import spm_bg_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned pos;

  // Scan from farthest to nearest so the nearest request to ptr_i is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      pos = (int'(ptr_i) + k) % NumReq;
      if (req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/spm_bg_arbiter.sv
// Per-bank-group burst arbiter: each group grants one LSU exclusive access for len+1 cycles.
module spm_bg_arbiter
  import spm_bg_arbiter_pkg::*;
#(
  parameter int unsigned N_LSU = DefNLsu,
  parameter int unsigned N_BG  = DefNBg,
  parameter int unsigned LEN_W = DefLenW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_LSU-1:0]        req_valid,
  input  logic [N_LSU*IdxW-1:0]   req_bg,
  input  logic [N_LSU*LEN_W-1:0]  req_len,
  output logic [N_LSU-1:0]        grant,
  output logic [N_BG-1:0]         bg_busy,
  output logic [N_BG*IdxW-1:0]    bg_owner,
  output logic [N_BG-1:0]         last_beat
);

  logic [N_LSU-1:0] bg_grant [N_BG];

  always_comb begin
    grant = '0;
    for (int b = 0; b < int'(N_BG); b++) begin
      grant |= bg_grant[b];
    end
  end

  for (genvar b = 0; b < N_BG; b++) begin : g_bg
    logic [0:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  owner_q, owner_d;
    logic [N_LSU-1:0] elig;
    logic [N_LSU-1:0] hold;
    logic             win_valid;
    logic [IdxW-1:0]  win_idx;
    logic             busy;

    // An LSU already holding a group (including in its last beat) may not compete.
    always_comb begin
      elig = '0;
      for (int i = 0; i < int'(N_LSU); i++) begin
        elig[i] = req_valid[i] && (req_bg[i*IdxW +: IdxW] == IdxW'(b)) && !grant[i];
      end
    end

    rr_arbiter_n #(
      .NumReq (N_LSU)
    ) u_rr (
      .req_i   (elig),
      .ptr_i   (ptr_q),
      .valid_o (win_valid),
      .idx_o   (win_idx)
    );

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_d = StBusy;
            cnt_d   = req_len[int'(win_idx)*LEN_W +: LEN_W];
            ptr_d   = rr_next(win_idx, N_LSU);
            owner_d = win_idx;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        ptr_q   <= '0;
        owner_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ptr_q   <= ptr_d;
        owner_q <= owner_d;
      end
    end

    assign busy = (state_q == StBusy);

    always_comb begin
      hold = '0;
      for (int i = 0; i < int'(N_LSU); i++) begin
        hold[i] = busy && (owner_q == IdxW'(i));
      end
    end

    assign bg_grant[b]                = hold;
    assign bg_busy[b]                 = busy;
    assign last_beat[b]               = busy && (cnt_q == '0);
    assign bg_owner[b*IdxW +: IdxW]   = owner_q;
  end

endmodule

// File: tb/tb_spm_bg_arbiter.sv
// Directed and randomized check of spm_bg_arbiter against a burst-level reference model.
module tb_spm_bg_arbiter;

  localparam int NL = 4;
  localparam int NB = 4;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NL-1:0]   req_valid;
  logic [2*NL-1:0] req_bg;
  logic [NL*LW-1:0] req_len;
  logic [NL-1:0]   grant;
  logic [NB-1:0]   bg_busy;
  logic [2*NB-1:0] bg_owner;
  logic [NB-1:0]   last_beat;

  int checks   = 0;
  int failures = 0;

  // Model: remaining granted cycles per group (0 = idle), owner, next search start.
  int rem [NB];
  int own [NB];
  int ptr [NB];

  spm_bg_arbiter #(
    .N_LSU (NL),
    .N_BG  (NB),
    .LEN_W (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bg    (req_bg),
    .req_len   (req_len),
    .grant     (grant),
    .bg_busy   (bg_busy),
    .bg_owner  (bg_owner),
    .last_beat (last_beat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [NL-1:0]   eg;
    logic [NB-1:0]   eb;
    logic [NB-1:0]   el;
    logic [2*NB-1:0] eo;
    eg = '0;
    eb = '0;
    el = '0;
    eo = '0;
    for (int b = 0; b < NB; b++) begin
      eb[b]        = rem[b] > 0;
      el[b]        = rem[b] == 1;
      eo[2*b +: 2] = 2'(own[b]);
      if (rem[b] > 0) eg[own[b]] = 1'b1;
    end
    check("grant", 32'(grant), 32'(eg));
    check("bg_busy", 32'(bg_busy), 32'(eb));
    check("bg_owner", 32'(bg_owner), 32'(eo));
    check("last_beat", 32'(last_beat), 32'(el));
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit owning [NL];
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        rem[b] = 0;
        own[b] = 0;
        ptr[b] = 0;
      end
      return;
    end
    for (int i = 0; i < NL; i++) owning[i] = 1'b0;
    for (int b = 0; b < NB; b++) if (rem[b] > 0) owning[own[b]] = 1'b1;
    for (int b = 0; b < NB; b++) begin
      if (rem[b] > 0) begin
        rem[b]--;
      end else begin
        for (int k = 0; k < NL; k++) begin
          int i;
          i = (ptr[b] + k) % NL;
          if (req_valid[i] && int'(req_bg[2*i +: 2]) == b && !owning[i]) begin
            own[b] = i;
            rem[b] = int'(req_len[LW*i +: LW]) + 1;
            ptr[b] = (i + 1) % NL;
            break;
          end
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic [NL-1:0] v, input logic [2*NL-1:0] bg,
                      input logic [NL*LW-1:0] ln);
    @(negedge clk);
    compare_outputs();
    rst       = r;
    req_valid = v;
    req_bg    = bg;
    req_len   = ln;
    model_step();
  endtask

  task automatic do_reset();
    tick(1'b1, '0, '0, '0);
    tick(1'b1, '0, '0, '0);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int seq [$];
    rst       = 1'b1;
    req_valid = '0;
    req_bg    = '0;
    req_len   = '0;
    for (int b = 0; b < NB; b++) begin
      rem[b] = 0;
      own[b] = 0;
      ptr[b] = 0;
    end
    do_reset();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(bg_busy), 32'h0);

    // Single request: LSU0 -> bg2, len 3.
    tick(1'b0, 4'b0001, 8'h02, 16'h0003);
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, '0, '0, '0);
      cnt_a += int'(grant[0] && bg_busy[2] && bg_owner[5:4] == 2'd0);
      cnt_b += int'(last_beat[2]);
    end
    check("single_grant_cycles", 32'(cnt_a), 32'd4);
    check("single_last_pulses", 32'(cnt_b), 32'd1);

    // Contention: all LSUs on bg1, len 0, held from reset.
    do_reset();
    tick(1'b0, 4'hf, 8'h55, 16'h0000);
    cnt_a = 0;
    seq.delete();
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'hf, 8'h55, 16'h0000);
      if (bg_busy[1]) begin
        cnt_a++;
        seq.push_back(int'(bg_owner[3:2]));
      end
    end
    check("cont_grants", 32'(cnt_a), 32'd5);
    check("cont_order0", 32'(seq.size() > 0 ? seq[0] : -1), 32'd0);
    check("cont_order1", 32'(seq.size() > 1 ? seq[1] : -1), 32'd1);
    check("cont_order3", 32'(seq.size() > 3 ? seq[3] : -1), 32'd3);
    check("cont_order4", 32'(seq.size() > 4 ? seq[4] : -1), 32'd0);

    // Parallel: LSUi -> bgi, len 1.
    do_reset();
    tick(1'b0, 4'hf, 8'he4, 16'h1111);
    tick(1'b0, '0, '0, '0);
    check("par_owner", 32'(bg_owner), 32'he4);
    cnt_a = int'(grant == 4'hf);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, '0, '0, '0);
      cnt_a += int'(grant == 4'hf);
    end
    check("par_all_grant_cycles", 32'(cnt_a), 32'd2);

    // Hold: LSU2 -> bg3 len 7, then drops valid and retargets bg0.
    do_reset();
    tick(1'b0, 4'b0100, 8'h30, 16'h0700);
    tick(1'b0, 4'b0100, 8'h30, 16'h0700);
    cnt_a = int'(grant[2]);
    cnt_b = int'(bg_busy[0]);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0000, 8'h00, 16'h0300);
      cnt_a += int'(grant[2]);
      cnt_b += int'(bg_busy[0]);
    end
    check("hold_grant_cycles", 32'(cnt_a), 32'd8);
    check("hold_bg0_busy", 32'(cnt_b), 32'd0);

    // Reset on the third beat of a len 5 burst.
    do_reset();
    tick(1'b0, 4'b0001, 8'h00, 16'h0005);
    tick(1'b0, '0, '0, '0);
    tick(1'b0, '0, '0, '0);
    tick(1'b1, '0, '0, '0);
    tick(1'b0, '0, '0, '0);
    check("rst_abort", 32'({grant, bg_busy, last_beat}), 32'h0);
    cnt_a = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, '0, '0, '0);
      cnt_a += int'(bg_busy != '0);
    end
    check("rst_no_resume", 32'(cnt_a), 32'd0);

    // Max length: len 15 on bg1 from LSU3.
    do_reset();
    tick(1'b0, 4'b1000, 8'h40, 16'hf000);
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, '0, '0, '0);
      cnt_a += int'(grant[3]);
      cnt_b += int'(last_beat[1]);
    end
    check("max_grant_cycles", 32'(cnt_a), 32'd16);
    check("max_last_pulses", 32'(cnt_b), 32'd1);

    // Randomized traffic, checked every cycle against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [NL*LW-1:0] ln;
      ln = ($urandom_range(0, 7) == 0) ? (NL*LW)'($urandom) : (NL*LW)'($urandom & 32'h3333);
      tick(($urandom_range(0, 199) == 0), NL'($urandom), (2*NL)'($urandom), ln);
    end
    tick(1'b0, '0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
